// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle control sequencer:
// opcodes, datapath mux selects, ALU operations, trap causes and FSM states.
package rv_ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALUOP_ADD   = 4'b0000;
    localparam logic [3:0] ALUOP_AUIPC = 4'b0001;
    localparam logic [3:0] ALUOP_BRCMP = 4'b0010;
    localparam logic [3:0] ALUOP_IFN   = 4'b0011;
    localparam logic [3:0] ALUOP_LUI   = 4'b0101;
    localparam logic [3:0] ALUOP_RFN   = 4'b0111;

    localparam logic [1:0] WB_ALUOUT = 2'b00;
    localparam logic [1:0] WB_MDR    = 2'b01;
    localparam logic [1:0] WB_PC     = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JALR   = 2'b10;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH      = 4'd0,
        S_DECODE     = 4'd1,
        S_EXEC_R     = 4'd2,
        S_EXEC_I     = 4'd3,
        S_ADDR       = 4'd4,
        S_MEM_RD     = 4'd5,
        S_MEM_WR     = 4'd6,
        S_WB_MEM     = 4'd7,
        S_WB_ALU     = 4'd8,
        S_EXEC_B     = 4'd9,
        S_EXEC_J     = 4'd10,
        S_EXEC_JR    = 4'd11,
        S_EXEC_LUI   = 4'd12,
        S_EXEC_AUIPC = 4'd13,
        S_TRAP       = 4'd14
    } state_e;

    // States that stall on the shared memory port and are guarded by the timer.
    function automatic logic is_mem_wait(input state_e st);
        return (st == S_FETCH) || (st == S_MEM_RD) || (st == S_MEM_WR);
    endfunction

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multi-cycle sequencer (master) and the datapath/memory (slave).
interface multicycle_control_fsm_if #(parameter int CNT_W = 32);

    logic [6:0]       opcode;
    logic             br_cond;
    logic             mem_ready;
    logic             pc_write;
    logic             ir_write;
    logic             iord;
    logic             memread;
    logic             memwrite;
    logic             regwrite;
    logic [1:0]       wb_sel;
    logic [1:0]       alusrc_a;
    logic [1:0]       alusrc_b;
    logic [3:0]       aluop;
    logic [1:0]       pc_src;
    logic             trap;
    logic [1:0]       trap_cause;
    logic [CNT_W-1:0] instret;

    modport master (
        input  opcode, br_cond, mem_ready,
        output pc_write, ir_write, iord, memread, memwrite, regwrite,
               wb_sel, alusrc_a, alusrc_b, aluop, pc_src,
               trap, trap_cause, instret
    );

    modport slave (
        output opcode, br_cond, mem_ready,
        input  pc_write, ir_write, iord, memread, memwrite, regwrite,
               wb_sel, alusrc_a, alusrc_b, aluop, pc_src,
               trap, trap_cause, instret
    );

endinterface

// File: rtl/mem_wait_timer.sv
// Counts stalled memory cycles; expired flags the last allowed cycle of a wait.
module mem_wait_timer #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

    logic [CW-1:0] count_r;

    // Wait-cycle counter, saturating at the last allowed cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= {CW{1'b0}};
        end else if (clear) begin
            count_r <= {CW{1'b0}};
        end else if (enable && (count_r != LAST)) begin
            count_r <= count_r + CW'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = (count_r == LAST);

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I control sequencer: Moore strobes per state, memory handshake
// with timeout trap, illegal-opcode trap and retired-instruction counter.
module multicycle_control_fsm
    import rv_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    multicycle_control_fsm_if.master bus
);

    state_e           state_r, state_next_s;
    logic [1:0]       cause_r, cause_next_s;
    logic [CNT_W-1:0] instret_r;
    logic             retire_s;
    logic             wait_s;
    logic             clear_s;
    logic             expired_s;

    assign wait_s  = is_mem_wait(state_r) && !bus.mem_ready;
    assign clear_s = (state_next_s != state_r);

    mem_wait_timer #(.LIMIT(MEM_TIMEOUT)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (clear_s),
        .enable  (wait_s),
        .expired (expired_s)
    );

    // State, trap cause and retired-instruction counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= S_FETCH;
            cause_r   <= CAUSE_NONE;
            instret_r <= {CNT_W{1'b0}};
        end else begin
            state_r   <= state_next_s;
            cause_r   <= cause_next_s;
            instret_r <= retire_s ? (instret_r + CNT_W'(1)) : instret_r;
        end
    end

    // Next-state decode and per-state strobes; reset forces every strobe low.
    always_comb begin
        state_next_s  = state_r;
        cause_next_s  = cause_r;
        retire_s      = 1'b0;
        bus.pc_write  = 1'b0;
        bus.ir_write  = 1'b0;
        bus.iord      = 1'b0;
        bus.memread   = 1'b0;
        bus.memwrite  = 1'b0;
        bus.regwrite  = 1'b0;
        bus.wb_sel    = WB_ALUOUT;
        bus.alusrc_a  = SRCA_PC;
        bus.alusrc_b  = SRCB_RS2;
        bus.aluop     = ALUOP_ADD;
        bus.pc_src    = PCSRC_ALU;
        bus.trap      = 1'b0;
        if (reset) begin
            state_next_s = S_FETCH;
            cause_next_s = CAUSE_NONE;
        end else begin
            case (state_r)
                S_FETCH: begin
                    bus.memread  = 1'b1;
                    bus.alusrc_b = SRCB_FOUR;
                    if (bus.mem_ready) begin
                        bus.ir_write = 1'b1;
                        bus.pc_write = 1'b1;
                        state_next_s = S_DECODE;
                    end else if (expired_s) begin
                        state_next_s = S_TRAP;
                        cause_next_s = CAUSE_TIMEOUT;
                    end else begin
                        state_next_s = S_FETCH;
                    end
                end
                S_DECODE: begin
                    bus.alusrc_a = SRCA_OLDPC;
                    bus.alusrc_b = SRCB_IMM;
                    case (bus.opcode)
                        OP_R:      state_next_s = S_EXEC_R;
                        OP_I:      state_next_s = S_EXEC_I;
                        OP_LOAD:   state_next_s = S_ADDR;
                        OP_STORE:  state_next_s = S_ADDR;
                        OP_BRANCH: state_next_s = S_EXEC_B;
                        OP_JAL:    state_next_s = S_EXEC_J;
                        OP_JALR:   state_next_s = S_EXEC_JR;
                        OP_LUI:    state_next_s = S_EXEC_LUI;
                        OP_AUIPC:  state_next_s = S_EXEC_AUIPC;
                        default: begin
                            state_next_s = S_TRAP;
                            cause_next_s = CAUSE_ILLEGAL;
                        end
                    endcase
                end
                S_EXEC_R: begin
                    bus.alusrc_a = SRCA_RS1;
                    bus.aluop    = ALUOP_RFN;
                    state_next_s = S_WB_ALU;
                end
                S_EXEC_I: begin
                    bus.alusrc_a = SRCA_RS1;
                    bus.alusrc_b = SRCB_IMM;
                    bus.aluop    = ALUOP_IFN;
                    state_next_s = S_WB_ALU;
                end
                S_EXEC_LUI: begin
                    bus.alusrc_a = SRCA_ZERO;
                    bus.alusrc_b = SRCB_IMM;
                    bus.aluop    = ALUOP_LUI;
                    state_next_s = S_WB_ALU;
                end
                S_EXEC_AUIPC: begin
                    bus.alusrc_a = SRCA_OLDPC;
                    bus.alusrc_b = SRCB_IMM;
                    bus.aluop    = ALUOP_AUIPC;
                    state_next_s = S_WB_ALU;
                end
                S_WB_ALU: begin
                    bus.regwrite = 1'b1;
                    retire_s     = 1'b1;
                    state_next_s = S_FETCH;
                end
                S_ADDR: begin
                    bus.alusrc_a = SRCA_RS1;
                    bus.alusrc_b = SRCB_IMM;
                    state_next_s = bus.opcode[5] ? S_MEM_WR : S_MEM_RD;
                end
                S_MEM_RD: begin
                    bus.memread = 1'b1;
                    bus.iord    = 1'b1;
                    if (bus.mem_ready) begin
                        state_next_s = S_WB_MEM;
                    end else if (expired_s) begin
                        state_next_s = S_TRAP;
                        cause_next_s = CAUSE_TIMEOUT;
                    end else begin
                        state_next_s = S_MEM_RD;
                    end
                end
                S_MEM_WR: begin
                    bus.memwrite = 1'b1;
                    bus.iord     = 1'b1;
                    if (bus.mem_ready) begin
                        retire_s     = 1'b1;
                        state_next_s = S_FETCH;
                    end else if (expired_s) begin
                        state_next_s = S_TRAP;
                        cause_next_s = CAUSE_TIMEOUT;
                    end else begin
                        state_next_s = S_MEM_WR;
                    end
                end
                S_WB_MEM: begin
                    bus.regwrite = 1'b1;
                    bus.wb_sel   = WB_MDR;
                    retire_s     = 1'b1;
                    state_next_s = S_FETCH;
                end
                S_EXEC_B: begin
                    bus.alusrc_a = SRCA_RS1;
                    bus.aluop    = ALUOP_BRCMP;
                    bus.pc_src   = PCSRC_ALUOUT;
                    bus.pc_write = bus.br_cond;
                    retire_s     = 1'b1;
                    state_next_s = S_FETCH;
                end
                S_EXEC_J: begin
                    bus.regwrite = 1'b1;
                    bus.wb_sel   = WB_PC;
                    bus.pc_write = 1'b1;
                    bus.pc_src   = PCSRC_ALUOUT;
                    retire_s     = 1'b1;
                    state_next_s = S_FETCH;
                end
                S_EXEC_JR: begin
                    bus.alusrc_a = SRCA_RS1;
                    bus.alusrc_b = SRCB_IMM;
                    bus.regwrite = 1'b1;
                    bus.wb_sel   = WB_PC;
                    bus.pc_write = 1'b1;
                    bus.pc_src   = PCSRC_JALR;
                    retire_s     = 1'b1;
                    state_next_s = S_FETCH;
                end
                S_TRAP: begin
                    bus.trap     = 1'b1;
                    state_next_s = S_TRAP;
                end
                default: begin
                    state_next_s = S_TRAP;
                    cause_next_s = CAUSE_ILLEGAL;
                end
            endcase
        end
    end

    assign bus.trap_cause = cause_r;
    assign bus.instret    = instret_r;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: per-cycle strobe checks for each
// instruction class, memory wait, traps and reset recovery.
module tb_multicycle_control_fsm;

    logic clk;
    logic reset;
    int   tests_run;
    int   tests_failed;
    int   cnt;

    multicycle_control_fsm_if #(.CNT_W(32)) bus ();

    multicycle_control_fsm #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {pc_write, ir_write, iord, memread, memwrite, regwrite, wb_sel, alusrc_a, alusrc_b, aluop, pc_src}
    logic [17:0] strobes;
    assign strobes = {bus.pc_write, bus.ir_write, bus.iord, bus.memread, bus.memwrite,
                      bus.regwrite, bus.wb_sel, bus.alusrc_a, bus.alusrc_b, bus.aluop, bus.pc_src};

    // Strobe vectors per state (mem_ready/br_cond as noted)
    localparam logic [17:0] V_FETCH_RDY  = {1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,2'b00,2'b00,2'b01,4'b0000,2'b00};
    localparam logic [17:0] V_FETCH_WAIT = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,2'b00,2'b01,4'b0000,2'b00};
    localparam logic [17:0] V_DECODE     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b10,4'b0000,2'b00};
    localparam logic [17:0] V_EXEC_R     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b00,4'b0111,2'b00};
    localparam logic [17:0] V_WB_ALU     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,2'b00,4'b0000,2'b00};
    localparam logic [17:0] V_ADDR       = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b10,4'b0000,2'b00};
    localparam logic [17:0] V_MEM_RD     = {1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,2'b00,2'b00,2'b00,4'b0000,2'b00};
    localparam logic [17:0] V_MEM_WR     = {1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,4'b0000,2'b00};
    localparam logic [17:0] V_WB_MEM     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b01,2'b00,2'b00,4'b0000,2'b00};
    localparam logic [17:0] V_EXEC_B0    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b00,4'b0010,2'b01};
    localparam logic [17:0] V_EXEC_B1    = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b00,4'b0010,2'b01};
    localparam logic [17:0] V_EXEC_J     = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,4'b0000,2'b01};
    localparam logic [17:0] V_EXEC_JR    = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b10,2'b10,4'b0000,2'b10};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.mem_ready = 1'b1;
        bus.opcode = 7'b0110011;
        bus.br_cond = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests_run++;
            if (strobes !== 18'd0 || bus.trap !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_strobes cycle %0d: got %b trap %b, want 0", i, strobes, bus.trap);
            end
            tick();
        end
        reset = 1'b0;
        #1;
        tests_run++;
        if (bus.memread !== 1'b1 || bus.iord !== 1'b0 || bus.instret !== 32'd0 || bus.trap_cause !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_first_fetch: memread %b iord %b instret %0d cause %b, want 1 0 0 00",
                     bus.memread, bus.iord, bus.instret, bus.trap_cause);
        end
    endtask

    task automatic test_r_type();
        logic [17:0] exp_s [4];
        exp_s = '{V_FETCH_RDY, V_DECODE, V_EXEC_R, V_WB_ALU};
        bus.opcode = 7'b0110011;
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            tests_run++;
            if (strobes !== exp_s[i]) begin
                tests_failed++;
                $display("FAIL r_type cycle %0d: got %b want %b", i + 1, strobes, exp_s[i]);
            end
            tick();
        end
        tests_run++;
        if (bus.instret !== 32'd1 || bus.memread !== 1'b1) begin
            tests_failed++;
            $display("FAIL r_type_retire: instret %0d memread %b, want 1 1", bus.instret, bus.memread);
        end
    endtask

    task automatic test_load_wait();
        logic [17:0] exp_s [8];
        exp_s = '{V_FETCH_RDY, V_DECODE, V_ADDR, V_MEM_RD, V_MEM_RD, V_MEM_RD, V_MEM_RD, V_WB_MEM};
        bus.opcode = 7'b0000011;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            bus.mem_ready = (i >= 3 && i <= 5) ? 1'b0 : 1'b1;
            #1;
            if (bus.memread === 1'b1 && bus.iord === 1'b1) cnt++;
            tests_run++;
            if (strobes !== exp_s[i]) begin
                tests_failed++;
                $display("FAIL load cycle %0d: got %b want %b", i + 1, strobes, exp_s[i]);
            end
            tick();
        end
        tests_run++;
        if (cnt !== 4 || bus.instret !== 32'd2 || bus.memread !== 1'b1) begin
            tests_failed++;
            $display("FAIL load_totals: memread cycles %0d instret %0d fetch %b, want 4 2 1",
                     cnt, bus.instret, bus.memread);
        end
    endtask

    task automatic test_branch_jump();
        logic [6:0]  op_s  [4];
        logic        bc_s  [4];
        logic [17:0] ex_s  [4];
        op_s = '{7'b1100011, 7'b1100011, 7'b1101111, 7'b1100111};
        bc_s = '{1'b0, 1'b1, 1'b0, 1'b0};
        ex_s = '{V_EXEC_B0, V_EXEC_B1, V_EXEC_J, V_EXEC_JR};
        bus.mem_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.opcode  = op_s[k];
            bus.br_cond = bc_s[k];
            tick();
            tick();
            #1;
            tests_run++;
            if (strobes !== ex_s[k]) begin
                tests_failed++;
                $display("FAIL branch_jump %0d cycle 3: got %b want %b", k, strobes, ex_s[k]);
            end
            tick();
            tests_run++;
            if (bus.instret !== 32'(3 + k) || bus.memread !== 1'b1) begin
                tests_failed++;
                $display("FAIL branch_jump_retire %0d: instret %0d fetch %b, want %0d 1",
                         k, bus.instret, bus.memread, 3 + k);
            end
        end
        bus.br_cond = 1'b0;
    endtask

    task automatic test_store();
        bus.opcode = 7'b0100011;
        bus.mem_ready = 1'b1;
        tick();
        tick();
        #1;
        tests_run++;
        if (strobes !== V_ADDR) begin
            tests_failed++;
            $display("FAIL store_addr: got %b want %b", strobes, V_ADDR);
        end
        tick();
        tests_run++;
        if (strobes !== V_MEM_WR) begin
            tests_failed++;
            $display("FAIL store_memwr: got %b want %b", strobes, V_MEM_WR);
        end
        tick();
        tests_run++;
        if (bus.instret !== 32'd7 || bus.memread !== 1'b1) begin
            tests_failed++;
            $display("FAIL store_retire: instret %0d fetch %b, want 7 1", bus.instret, bus.memread);
        end
    endtask

    task automatic test_illegal();
        bus.opcode = 7'b1111111;
        bus.mem_ready = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 20; i++) begin
            bus.mem_ready = i[0];
            bus.br_cond   = i[1];
            #1;
            tests_run++;
            if (strobes !== 18'd0 || bus.trap !== 1'b1 || bus.trap_cause !== 2'b01 || bus.instret !== 32'd7) begin
                tests_failed++;
                $display("FAIL illegal_trap cycle %0d: strobes %b trap %b cause %b instret %0d, want 0 1 01 7",
                         i, strobes, bus.trap, bus.trap_cause, bus.instret);
            end
            tick();
        end
        bus.br_cond = 1'b0;
        bus.mem_ready = 1'b1;
        reset = 1'b1;
        #1;
        tests_run++;
        if (strobes !== 18'd0 || bus.trap !== 1'b0) begin
            tests_failed++;
            $display("FAIL trap_reset_gate: strobes %b trap %b, want 0 0", strobes, bus.trap);
        end
        tick();
        reset = 1'b0;
        #1;
        tests_run++;
        if (strobes !== V_FETCH_RDY || bus.trap !== 1'b0 || bus.trap_cause !== 2'b00 || bus.instret !== 32'd0) begin
            tests_failed++;
            $display("FAIL trap_recover: strobes %b trap %b cause %b instret %0d, want fetch 0 00 0",
                     strobes, bus.trap, bus.trap_cause, bus.instret);
        end
    endtask

    task automatic test_timeout();
        for (int pass = 0; pass < 2; pass++) begin
            bus.opcode = 7'b0110011;
            for (int c = 1; c <= 16; c++) begin
                bus.mem_ready = (pass == 1 && c == 16) ? 1'b1 : 1'b0;
                #1;
                tests_run++;
                if (bus.memread !== 1'b1 || bus.trap !== 1'b0 || bus.ir_write !== bus.mem_ready) begin
                    tests_failed++;
                    $display("FAIL timeout_wait pass %0d cycle %0d: memread %b trap %b ir_write %b",
                             pass, c, bus.memread, bus.trap, bus.ir_write);
                end
                tick();
            end
            bus.mem_ready = 1'b0;
            #1;
            tests_run++;
            if (pass == 0) begin
                if (bus.trap !== 1'b1 || bus.trap_cause !== 2'b10 || strobes !== 18'd0) begin
                    tests_failed++;
                    $display("FAIL timeout_trap: trap %b cause %b strobes %b, want 1 10 0",
                             bus.trap, bus.trap_cause, strobes);
                end
            end else begin
                if (bus.trap !== 1'b0 || strobes !== V_DECODE) begin
                    tests_failed++;
                    $display("FAIL timeout_race: trap %b strobes %b, want 0 %b", bus.trap, strobes, V_DECODE);
                end
            end
            reset = 1'b1;
            tick();
            reset = 1'b0;
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        test_reset();
        test_r_type();
        test_load_wait();
        test_branch_jump();
        test_store();
        test_illegal();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
